ordenador_sram: RTL and testbench



---
 rtl/ordenador_sram_pkg.sv | 27 ++
 rtl/ordenador_sram_dp.sv | 86 ++++++++
 rtl/ordenador_sram.sv | 199 +++++++++++++++++++
 tb/tb_ordenador_sram.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ordenador_sram_pkg.sv
// Shared definitions for the in-place SRAM bubble sorter: SRAM widths,
// controller state encoding and a saturating counter helper.
package ordenador_sram_pkg;

   localparam int unsigned SRAM_AW = 8;
   localparam int unsigned SRAM_DW = 8;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      RD_A  = 4'd1,
      RD_B  = 4'd2,
      CMP   = 4'd3,
      SET_A = 4'd4,
      WR_A  = 4'd5,
      SET_B = 4'd6,
      WR_B  = 4'd7,
      PASS  = 4'd8,
      FIN   = 4'd9
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/ordenador_sram_dp.sv
// Sorter datapath: operand latches, pair index, pass/swap counters and the
// "swap happened this pass" flag, all sequenced by strobes from the FSM.
module ordenador_dp
   import ordenador_sram_pkg::*;
#(
   parameter int unsigned N_ELEM = 12,
   parameter int unsigned AW     = SRAM_AW,
   parameter int unsigned DW     = SRAM_DW
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_cap_a,
   input  logic             i_cap_b,
   input  logic             i_j_inc,
   input  logic             i_j_rst,
   input  logic             i_swap,
   input  logic             i_pass,
   input  logic [DW-1:0]    i_dato_s,
   output logic [DW-1:0]    o_a,
   output logic [DW-1:0]    o_b,
   output logic [AW-1:0]    o_j,
   output logic             o_hubo_swap,
   output logic             o_gt_c,
   output logic             o_last_c,
   output logic [CNT_W-1:0] o_pasadas,
   output logic [CNT_W-1:0] o_intercambios
);

   // Index of the last pair (j, j+1) inside the array.
   localparam int unsigned LAST_J = (N_ELEM >= 2) ? N_ELEM - 2 : 0;

   logic [DW-1:0]    r_a;
   logic [DW-1:0]    r_b;
   logic [AW-1:0]    r_j;
   logic             r_hubo_swap;
   logic [CNT_W-1:0] r_pasadas;
   logic [CNT_W-1:0] r_intercambios;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a            <= '0;
         r_b            <= '0;
         r_j            <= '0;
         r_hubo_swap    <= 1'b0;
         r_pasadas      <= '0;
         r_intercambios <= '0;
      end else begin
         if (i_cap_a) r_a <= i_dato_s;
         if (i_cap_b) r_b <= i_dato_s;

         if (i_clr || i_j_rst) begin
            r_j <= '0;
         end else if (i_j_inc) begin
            r_j <= r_j + AW'(1);
         end

         if (i_clr) begin
            r_pasadas      <= '0;
            r_intercambios <= '0;
            r_hubo_swap    <= 1'b0;
         end else begin
            if (i_swap) begin
               r_intercambios <= sat_inc(r_intercambios);
               r_hubo_swap    <= 1'b1;
            end
            // End of pass always rearms the flag for the next pass.
            if (i_pass) begin
               r_pasadas   <= sat_inc(r_pasadas);
               r_hubo_swap <= 1'b0;
            end
         end
      end
   end

   assign o_a            = r_a;
   assign o_b            = r_b;
   assign o_j            = r_j;
   assign o_hubo_swap    = r_hubo_swap;
   assign o_pasadas      = r_pasadas;
   assign o_intercambios = r_intercambios;
   assign o_gt_c         = (r_a > r_b);
   assign o_last_c       = (r_j == AW'(LAST_J));

endmodule

// File: rtl/ordenador_sram.sv
// Bubble-sort controller in front of a single-port async-read SRAM: sorts
// words 0..N_ELEM-1 ascending in place and reports passes and swaps.
module ordenador_sram
   import ordenador_sram_pkg::*;
#(
   parameter int unsigned N_ELEM = 12,
   parameter int unsigned AW     = SRAM_AW,
   parameter int unsigned DW     = SRAM_DW
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pasadas,
   output logic [CNT_W-1:0] intercambios,
   output logic [AW-1:0]    Dir,
   output logic [DW-1:0]    Dato_e,
   output logic             En,
   output logic             We,
   input  logic [DW-1:0]    Dato_s
);

   state_t        r_state;
   logic          r_busy;
   logic          r_done;
   logic [AW-1:0] r_dir;
   logic [DW-1:0] r_dato_e;
   logic          r_en;
   logic          r_we;

   logic [DW-1:0] w_a;
   logic [DW-1:0] w_b;
   logic [AW-1:0] w_j;
   logic [AW-1:0] w_j_nxt;
   logic          w_hubo_swap;
   logic          w_gt;
   logic          w_last;
   logic          w_clr;
   logic          w_cap_a;
   logic          w_cap_b;
   logic          w_j_inc;
   logic          w_j_rst;
   logic          w_swap;
   logic          w_pass;

   assign w_j_nxt = w_j + AW'(1);

   // Datapath strobes decoded from the current state.
   assign w_clr   = (r_state == IDLE) && start;
   assign w_cap_a = (r_state == RD_A);
   assign w_cap_b = (r_state == RD_B);
   assign w_j_inc = (((r_state == CMP) && !w_gt) || (r_state == WR_B)) && !w_last;
   assign w_j_rst = (r_state == PASS) && w_hubo_swap;
   assign w_swap  = (r_state == WR_B);
   assign w_pass  = (r_state == PASS);

   ordenador_dp #(
      .N_ELEM (N_ELEM),
      .AW     (AW),
      .DW     (DW)
   ) u_dp (
      .clk            (clk),
      .rst            (rst),
      .i_clr          (w_clr),
      .i_cap_a        (w_cap_a),
      .i_cap_b        (w_cap_b),
      .i_j_inc        (w_j_inc),
      .i_j_rst        (w_j_rst),
      .i_swap         (w_swap),
      .i_pass         (w_pass),
      .i_dato_s       (Dato_s),
      .o_a            (w_a),
      .o_b            (w_b),
      .o_j            (w_j),
      .o_hubo_swap    (w_hubo_swap),
      .o_gt_c         (w_gt),
      .o_last_c       (w_last),
      .o_pasadas      (pasadas),
      .o_intercambios (intercambios)
   );

   // SRAM pins are registered with the values the next state needs, so each
   // state sees a settled address (and data) for its whole cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dir    <= '0;
         r_dato_e <= '0;
         r_en     <= 1'b0;
         r_we     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_en   <= 1'b0;
               r_we   <= 1'b0;
               r_busy <= 1'b0;
               if (start) begin
                  if (N_ELEM < 2) begin
                     r_done  <= 1'b1;
                     r_state <= FIN;
                  end else begin
                     r_busy  <= 1'b1;
                     r_en    <= 1'b1;
                     r_dir   <= '0;
                     r_state <= RD_A;
                  end
               end
            end
            RD_A: begin
               r_dir   <= w_j_nxt;
               r_en    <= 1'b1;
               r_state <= RD_B;
            end
            RD_B: begin
               r_en    <= 1'b0;
               r_state <= CMP;
            end
            CMP: begin
               if (w_gt) begin
                  r_dir    <= w_j;
                  r_dato_e <= w_b;
                  r_state  <= SET_A;
               end else if (w_last) begin
                  r_state <= PASS;
               end else begin
                  r_dir   <= w_j_nxt;
                  r_en    <= 1'b1;
                  r_state <= RD_A;
               end
            end
            SET_A: begin
               r_en    <= 1'b1;
               r_we    <= 1'b1;
               r_state <= WR_A;
            end
            WR_A: begin
               r_en     <= 1'b0;
               r_we     <= 1'b0;
               r_dir    <= w_j_nxt;
               r_dato_e <= w_a;
               r_state  <= SET_B;
            end
            SET_B: begin
               r_en    <= 1'b1;
               r_we    <= 1'b1;
               r_state <= WR_B;
            end
            WR_B: begin
               r_we <= 1'b0;
               if (w_last) begin
                  r_en    <= 1'b0;
                  r_state <= PASS;
               end else begin
                  r_dir   <= w_j_nxt;
                  r_en    <= 1'b1;
                  r_state <= RD_A;
               end
            end
            PASS: begin
               if (w_hubo_swap) begin
                  r_dir   <= '0;
                  r_en    <= 1'b1;
                  r_state <= RD_A;
               end else begin
                  r_en    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= FIN;
               end
            end
            FIN: begin
               r_en    <= 1'b0;
               r_we    <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_en    <= 1'b0;
               r_we    <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign Dir    = r_dir;
   assign Dato_e = r_dato_e;
   assign En     = r_en;
   assign We     = r_we;

endmodule

// File: tb/tb_ordenador_sram.sv
// Bench for ordenador_sram: behavioural SRAM plus a bubble-sort reference
// model computing expected contents, pass/swap counts and completion cycle.
module tb_ordenador_sram;

   localparam int N = 12;

   logic       clk;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic [7:0] pasadas;
   logic [7:0] intercambios;
   logic [7:0] Dir;
   logic [7:0] Dato_e;
   logic       En;
   logic       We;
   logic [7:0] Dato_s;

   logic [7:0] mem [0:255];

   int n_tests = 0;
   int n_fail  = 0;

   int done_cnt = 0;
   int we_cnt   = 0;
   int stab_err = 0;
   int dir_err  = 0;
   logic [7:0] prev_dir;
   logic [7:0] prev_de;

   logic [7:0] exp_mem [N];
   int exp_pass;
   int exp_swaps;

   ordenador_sram #(.N_ELEM(N), .AW(8), .DW(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .pasadas      (pasadas),
      .intercambios (intercambios),
      .Dir          (Dir),
      .Dato_e       (Dato_e),
      .En           (En),
      .We           (We),
      .Dato_s       (Dato_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Async-read SRAM; writes land at the clock edge that ends a We cycle.
   assign Dato_s = mem[Dir];
   always @(posedge clk) begin
      if (En && We) mem[Dir] = Dato_e;
   end

   // Bus monitor: Dir/Dato_e must match the previous cycle on every write.
   always @(posedge clk) begin
      #1;
      if (done) done_cnt++;
      if (We) begin
         we_cnt++;
         if (!En || Dir !== prev_dir || Dato_e !== prev_de) stab_err++;
      end
      if (Dir >= 8'(N)) dir_err++;
      prev_dir = Dir;
      prev_de  = Dato_e;
   end

   function automatic int sat8(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   // Reference: textbook bubble sort with early exit over full-length passes.
   function automatic void model_from_mem();
      logic [7:0] t;
      bit swapped;
      for (int i = 0; i < N; i++) exp_mem[i] = mem[i];
      exp_pass  = 0;
      exp_swaps = 0;
      do begin
         swapped = 1'b0;
         for (int i = 0; i < N - 1; i++) begin
            if (exp_mem[i] > exp_mem[i+1]) begin
               t            = exp_mem[i];
               exp_mem[i]   = exp_mem[i+1];
               exp_mem[i+1] = t;
               exp_swaps++;
               swapped = 1'b1;
            end
         end
         exp_pass++;
      end while (swapped);
   endfunction

   // Cycle of done after the start edge: 3 per pair, 4 more per swap, 1 per pass.
   function automatic int exp_done_cycle();
      return exp_pass * ((N - 1) * 3 + 1) + 4 * exp_swaps + 1;
   endfunction

   function automatic int count_bad_words();
      int bad = 0;
      for (int i = 0; i < N; i++) if (mem[i] !== exp_mem[i]) bad++;
      return bad;
   endfunction

   // Pulse start, optionally pulse it again at busy cycle extra_at, and wait for done.
   task automatic run_sort(input int extra_at, output int done_cyc, output bit busy_ok);
      int k;
      bit got;
      done_cnt = 0;
      we_cnt   = 0;
      stab_err = 0;
      dir_err  = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      k        = 1;
      got      = 1'b0;
      busy_ok  = 1'b1;
      done_cyc = -1;
      while (!got && k < 5000) begin
         if (done) begin
            got      = 1'b1;
            done_cyc = k;
            if (busy !== 1'b0) busy_ok = 1'b0;
         end else if (busy !== 1'b1) begin
            busy_ok = 1'b0;
         end
         start = (k == extra_at);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL run_timeout: no done within %0d cycles", k);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic load_vals(input logic [7:0] v [N]);
      for (int i = 0; i < N; i++) mem[i] = v[i];
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({busy, done, En, We, pasadas, intercambios, Dir, Dato_e} !== 36'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b En=%b We=%b pas=%0d int=%0d Dir=%0d De=%0d, expected all 0",
                  busy, done, En, We, pasadas, intercambios, Dir, Dato_e);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({busy, En, We} !== 3'b000) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%b En=%b We=%b, expected 000", busy, En, We);
      end
   endtask

   task automatic test_mixed(input int extra_at, input string tag);
      logic [7:0] v [N] = '{90, 80, 40, 60, 50, 40, 30, 20, 10, 100, 101, 102};
      int dc;
      bit bok;
      load_vals(v);
      model_from_mem();
      run_sort(extra_at, dc, bok);
      n_tests++;
      if (count_bad_words() !== 0) begin
         n_fail++;
         $display("FAIL %s_data: %0d words wrong, expected 0", tag, count_bad_words());
      end
      n_tests++;
      if (pasadas !== 8'(sat8(exp_pass))) begin
         n_fail++;
         $display("FAIL %s_pasadas: got %0d expected %0d", tag, pasadas, sat8(exp_pass));
      end
      n_tests++;
      if (intercambios !== 8'(sat8(exp_swaps))) begin
         n_fail++;
         $display("FAIL %s_intercambios: got %0d expected %0d", tag, intercambios, sat8(exp_swaps));
      end
      n_tests++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_cnt);
      end
      n_tests++;
      if (busy !== 1'b0 || !bok) begin
         n_fail++;
         $display("FAIL %s_busy: got busy=%b profile_ok=%b expected 0 and 1", tag, busy, bok);
      end
      n_tests++;
      if (dc !== exp_done_cycle()) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d expected %0d", tag, dc, exp_done_cycle());
      end
   endtask

   task automatic test_sorted();
      logic [7:0] v [N];
      int dc;
      bit bok;
      for (int i = 0; i < N; i++) v[i] = 8'(i + 1);
      load_vals(v);
      run_sort(-1, dc, bok);
      n_tests++;
      if (dc !== 35) begin
         n_fail++;
         $display("FAIL sorted_latency: got %0d expected 35", dc);
      end
      n_tests++;
      if (we_cnt !== 0) begin
         n_fail++;
         $display("FAIL sorted_writes: got %0d expected 0", we_cnt);
      end
      n_tests++;
      if (pasadas !== 8'd1 || intercambios !== 8'd0) begin
         n_fail++;
         $display("FAIL sorted_counts: got pas=%0d int=%0d expected 1 and 0", pasadas, intercambios);
      end
      n_tests++;
      if (!bok || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL sorted_handshake: got profile_ok=%b done_pulses=%0d expected 1 and 1", bok, done_cnt);
      end
   endtask

   task automatic test_reverse();
      logic [7:0] v [N];
      int bad;
      int dc;
      bit bok;
      for (int i = 0; i < N; i++) v[i] = 8'(N - i);
      load_vals(v);
      run_sort(-1, dc, bok);
      bad = 0;
      for (int i = 0; i < N; i++) if (mem[i] !== 8'(i + 1)) bad++;
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL reverse_data: %0d words wrong, expected 0", bad);
      end
      n_tests++;
      if (intercambios !== 8'd66 || pasadas !== 8'd12) begin
         n_fail++;
         $display("FAIL reverse_counts: got int=%0d pas=%0d expected 66 and 12", intercambios, pasadas);
      end
      n_tests++;
      if (stab_err !== 0 || we_cnt !== 132) begin
         n_fail++;
         $display("FAIL reverse_write_bus: got unstable=%0d writes=%0d expected 0 and 132", stab_err, we_cnt);
      end
      n_tests++;
      if (dir_err !== 0) begin
         n_fail++;
         $display("FAIL reverse_dir_range: got %0d out-of-range cycles expected 0", dir_err);
      end
   endtask

   task automatic test_equal();
      logic [7:0] v [N];
      int dc;
      bit bok;
      for (int i = 0; i < N; i++) v[i] = 8'd7;
      load_vals(v);
      run_sort(-1, dc, bok);
      n_tests++;
      if (we_cnt !== 0 || intercambios !== 8'd0 || pasadas !== 8'd1) begin
         n_fail++;
         $display("FAIL equal_no_swap: got writes=%0d int=%0d pas=%0d expected 0 0 1", we_cnt, intercambios, pasadas);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] v [N] = '{90, 80, 40, 60, 50, 40, 30, 20, 10, 100, 101, 102};
      int k;
      int dc;
      bit bok;
      load_vals(v);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (We !== 1'b1 && k < 500) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (We !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_reach_write: got We=%b expected 1", We);
      end
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({En, We, busy, done, Dir, Dato_e, pasadas, intercambios} !== 36'd0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got En=%b We=%b busy=%b done=%b Dir=%0d De=%0d, expected all 0",
                  En, We, busy, done, Dir, Dato_e);
      end
      rst = 1'b0;
      @(negedge clk);
      model_from_mem();
      run_sort(-1, dc, bok);
      n_tests++;
      if (count_bad_words() !== 0 || intercambios !== 8'(sat8(exp_swaps)) || pasadas !== 8'(sat8(exp_pass))) begin
         n_fail++;
         $display("FAIL midrst_resort: got bad=%0d int=%0d pas=%0d expected 0 %0d %0d",
                  count_bad_words(), intercambios, pasadas, sat8(exp_swaps), sat8(exp_pass));
      end
   endtask

   task automatic test_random();
      logic [7:0] v [N];
      int dc;
      bit bok;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N; i++)
            v[i] = (r < 3) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
         load_vals(v);
         model_from_mem();
         run_sort(-1, dc, bok);
         n_tests++;
         if (count_bad_words() !== 0 || intercambios !== 8'(sat8(exp_swaps)) ||
             pasadas !== 8'(sat8(exp_pass)) || dc !== exp_done_cycle()) begin
            n_fail++;
            $display("FAIL random_%0d: got bad=%0d int=%0d pas=%0d cyc=%0d expected 0 %0d %0d %0d",
                     r, count_bad_words(), intercambios, pasadas, dc, sat8(exp_swaps), sat8(exp_pass), exp_done_cycle());
         end
         n_tests++;
         if (stab_err !== 0 || dir_err !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL random_bus_%0d: got unstable=%0d dir_oor=%0d done_pulses=%0d expected 0 0 1",
                     r, stab_err, dir_err, done_cnt);
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
      test_reset();
      test_mixed(-1, "mixed");
      test_sorted();
      test_reverse();
      test_equal();
      test_mixed(5, "start_busy");
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
